// File: rtl/gemm_cmd_issuer.sv
// GEMM custom-instruction issuer: captures an instruction from the stall controller,
// drives it to the systolic accelerator, collects the response and signals completion.
module gemm_cmd_issuer #(
    parameter int XLEN           = 32,
    parameter int FUNCT_W        = 7,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid,
    input  logic [FUNCT_W-1:0] instr_funct,
    input  logic               instr_xd,
    input  logic [4:0]         instr_rd,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    output logic               acc_cmd_valid,
    input  logic               acc_cmd_ready,
    output logic [FUNCT_W-1:0] acc_cmd_funct,
    output logic [XLEN-1:0]    acc_cmd_op1,
    output logic [XLEN-1:0]    acc_cmd_op2,
    input  logic               acc_resp_valid,
    output logic               acc_resp_ready,
    input  logic [XLEN-1:0]    acc_resp_data,
    output logic               done,
    output logic               wb_en,
    output logic [4:0]         wb_rd,
    output logic [XLEN-1:0]    wb_data,
    output logic               timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t           state;
    logic             xd_q;
    logic [4:0]       rd_q;
    logic             abort_q;
    logic [CNT_W-1:0] cnt;
    logic             timeout_hit;

    // A response on the final watchdog cycle still wins because it is checked first below.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            xd_q           <= 1'b0;
            rd_q           <= '0;
            abort_q        <= 1'b0;
            cnt            <= '0;
            acc_cmd_valid  <= 1'b0;
            acc_cmd_funct  <= '0;
            acc_cmd_op1    <= '0;
            acc_cmd_op2    <= '0;
            acc_resp_ready <= 1'b0;
            done           <= 1'b0;
            wb_en          <= 1'b0;
            wb_rd          <= '0;
            wb_data        <= '0;
            timeout_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid) begin
                        acc_cmd_funct <= instr_funct;
                        acc_cmd_op1   <= rs1_data;
                        acc_cmd_op2   <= rs2_data;
                        xd_q          <= instr_xd;
                        rd_q          <= instr_rd;
                        acc_cmd_valid <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (acc_cmd_ready) begin
                        acc_cmd_valid  <= 1'b0;
                        acc_resp_ready <= 1'b1;
                        cnt            <= '0;
                        state          <= WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (acc_resp_valid) begin
                        acc_resp_ready <= 1'b0;
                        done           <= 1'b1;
                        wb_en          <= xd_q;
                        wb_rd          <= rd_q;
                        wb_data        <= acc_resp_data;
                        state          <= DONE;
                    end else if (timeout_hit) begin
                        acc_resp_ready <= 1'b0;
                        abort_q        <= 1'b1;
                        timeout_err    <= 1'b1;
                        done           <= 1'b1;
                        wb_en          <= 1'b0;
                        wb_rd          <= rd_q;
                        wb_data        <= '0;
                        state          <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    wb_en   <= 1'b0;
                    cnt     <= '0;
                    abort_q <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_cmd_issuer.sv
// Scoreboard bench for gemm_cmd_issuer: expected commands and completions are queued
// when an instruction is issued and compared as the DUT hands them over.
module tb_gemm_cmd_issuer;

    localparam int XLEN = 32;
    localparam int FW   = 7;

    logic            clk;
    logic            rst_n;
    logic            valid;
    logic [FW-1:0]   instr_funct;
    logic            instr_xd;
    logic [4:0]      instr_rd;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            acc_cmd_valid;
    logic            acc_cmd_ready;
    logic [FW-1:0]   acc_cmd_funct;
    logic [XLEN-1:0] acc_cmd_op1;
    logic [XLEN-1:0] acc_cmd_op2;
    logic            acc_resp_valid;
    logic            acc_resp_ready;
    logic [XLEN-1:0] acc_resp_data;
    logic            done;
    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            timeout_err;

    gemm_cmd_issuer #(.XLEN(XLEN), .FUNCT_W(FW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid),
        .instr_funct(instr_funct), .instr_xd(instr_xd), .instr_rd(instr_rd),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .acc_cmd_valid(acc_cmd_valid), .acc_cmd_ready(acc_cmd_ready),
        .acc_cmd_funct(acc_cmd_funct), .acc_cmd_op1(acc_cmd_op1), .acc_cmd_op2(acc_cmd_op2),
        .acc_resp_valid(acc_resp_valid), .acc_resp_ready(acc_resp_ready),
        .acc_resp_data(acc_resp_data),
        .done(done), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [FW-1:0]   funct;
        logic [XLEN-1:0] op1;
        logic [XLEN-1:0] op2;
    } cmd_t;

    typedef struct packed {
        logic            en;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_t;

    cmd_t cmd_q[$];
    wb_t  wb_q[$];
    cmd_t cmd_got;
    wb_t  wb_got;

    int n_chk  = 0;
    int n_pass = 0;
    int n_cmd  = 0;
    int n_done = 0;
    logic prev_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Handshake monitor: consumes one expected entry per accepted command / done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (acc_cmd_valid && acc_cmd_ready) begin
                n_cmd++;
                if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
                else begin
                    cmd_got = cmd_q.pop_front();
                    check("cmd_funct", acc_cmd_funct, cmd_got.funct);
                    check("cmd_op1", acc_cmd_op1, cmd_got.op1);
                    check("cmd_op2", acc_cmd_op2, cmd_got.op2);
                end
            end
            if (done) begin
                n_done++;
                check("done_width", prev_done, 0);
                if (wb_q.size() == 0) check("done_unexpected", 1, 0);
                else begin
                    wb_got = wb_q.pop_front();
                    check("wb_en", wb_en, wb_got.en);
                    check("wb_rd", wb_rd, wb_got.rd);
                    check("wb_data", wb_data, wb_got.data);
                end
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic send(input logic [FW-1:0] f, input logic xd, input logic [4:0] rd,
                        input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2,
                        input logic [XLEN-1:0] resp, input logic abort);
        wb_t w;
        cmd_q.push_back({f, op1, op2});
        w.en   = xd & ~abort;
        w.rd   = rd;
        w.data = abort ? '0 : resp;
        wb_q.push_back(w);
        @(posedge clk); #1;
        valid = 1'b1; instr_funct = f; instr_xd = xd; instr_rd = rd;
        rs1_data = op1; rs2_data = op2;
        @(posedge clk); #1;
        valid = 1'b0;
        rs1_data = '0; rs2_data = '0; instr_funct = '0;
    endtask

    task automatic stray_valid(input logic [XLEN-1:0] op);
        @(posedge clk); #1;
        valid = 1'b1; instr_funct = 7'h7F; rs1_data = op; rs2_data = ~op; instr_rd = 5'd31;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) check("done_timeout", 0, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd_valid"}, acc_cmd_valid, 0);
        check({tag, "_cmd_payload"}, {acc_cmd_funct, acc_cmd_op1, acc_cmd_op2}, 0);
        check({tag, "_resp_ready"}, acc_resp_ready, 0);
        check({tag, "_done_wb"}, {done, wb_en, wb_rd}, 0);
        check({tag, "_wb_data"}, wb_data, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        int wcnt;
        rst_n = 1'b1; valid = 1'b0; instr_funct = '0; instr_xd = 1'b0; instr_rd = '0;
        rs1_data = '0; rs2_data = '0; acc_cmd_ready = 1'b0; acc_resp_valid = 1'b0;
        acc_resp_data = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst_n = 1'b1;

        // 1: minimum latency, everything ready
        acc_cmd_ready = 1'b1; acc_resp_valid = 1'b1; acc_resp_data = 32'hCAFE;
        send(7'h01, 1'b1, 5'd5, 32'h1000, 32'h0010, 32'hCAFE, 1'b0);
        check("t1_cmd_valid_c1", acc_cmd_valid, 1);
        @(posedge clk); #1;
        check("t1_cmd_valid_c2", acc_cmd_valid, 0);
        check("t1_resp_ready_c2", acc_resp_ready, 1);
        @(posedge clk); #1;
        check("t1_done_c3", {done, wb_en, wb_rd}, {1'b1, 1'b1, 5'd5});
        check("t1_wb_data_c3", wb_data, 32'hCAFE);
        @(posedge clk); #1;
        check("t1_done_c4", done, 0);

        // 2: accelerator back-pressure for 10 cycles
        acc_cmd_ready = 1'b0; acc_resp_valid = 1'b0;
        n0 = n_cmd;
        send(7'h02, 1'b1, 5'd7, 32'hA5A5_0001, 32'h5A5A_0002, 32'h2222, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t2_cmd_hold", {acc_cmd_valid, acc_cmd_op1, acc_cmd_op2},
                  {1'b1, 32'hA5A5_0001, 32'h5A5A_0002});
        end
        acc_cmd_ready = 1'b1; acc_resp_valid = 1'b1; acc_resp_data = 32'h2222;
        wait_done(20);
        check("t2_one_cmd", n_cmd - n0, 1);

        // 3: no writeback requested
        acc_resp_data = 32'h1234;
        send(7'h03, 1'b0, 5'd9, 32'h3, 32'h4, 32'h1234, 1'b0);
        wait_done(10);
        @(negedge clk);
        check("t3_done_single", done, 0);

        // 6: stray valids and stray responses are ignored
        acc_cmd_ready = 1'b0; acc_resp_valid = 1'b1; acc_resp_data = 32'hDEAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_idle_resp_ready", {acc_resp_ready, done}, 0);
        end
        acc_resp_valid = 1'b0; acc_resp_data = 32'h5555;
        n0 = n_done;
        send(7'h06, 1'b1, 5'd12, 32'h6000, 32'h0600, 32'h5555, 1'b0);
        stray_valid(32'hBAD0_0001);
        @(negedge clk);
        check("t6_issue_op1", {acc_cmd_funct, acc_cmd_op1}, {7'h06, 32'h6000});
        acc_cmd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 acc_cmd_ready = 1'b0;
        stray_valid(32'hBAD0_0002);
        @(negedge clk);
        check("t6_wait_state", {acc_resp_ready, acc_cmd_valid, acc_cmd_op2}, {1'b1, 1'b0, 32'h0600});
        acc_resp_valid = 1'b1;
        wait_done(10);
        @(posedge clk); #1 acc_resp_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_one_done", n_done - n0, 1);
        check("t6_queues_empty", cmd_q.size() + wb_q.size(), 0);

        // 4: watchdog expiry, then a normal command
        acc_cmd_ready = 1'b1; acc_resp_valid = 1'b0;
        send(7'h04, 1'b1, 5'd3, 32'h4444, 32'h8888, 32'h0, 1'b1);
        wcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            if (acc_resp_ready) wcnt++;
        end
        check("t4_wait_cycles", wcnt, 8);
        check("t4_abort_flags", {done, wb_en, timeout_err}, {1'b1, 1'b0, 1'b1});
        acc_resp_valid = 1'b1; acc_resp_data = 32'h0BEE;
        send(7'h05, 1'b1, 5'd4, 32'h1, 32'h2, 32'h0BEE, 1'b0);
        wait_done(10);
        check("t4_err_sticky", timeout_err, 1);

        // 5: reset during WAIT_RESP
        acc_resp_valid = 1'b0;
        send(7'h08, 1'b1, 5'd8, 32'h8080, 32'h0808, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check_all_zero("t5_reset");
        void'(wb_q.pop_back());
        n0 = n_done;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_done", n_done - n0, 0);
        acc_resp_valid = 1'b1; acc_resp_data = 32'h7777;
        send(7'h09, 1'b1, 5'd10, 32'h9, 32'hA, 32'h7777, 1'b0);
        wait_done(10);
        repeat (2) @(negedge clk);
        check("final_queues_empty", cmd_q.size() + wb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
